// File: rtl/instr_fetch.sv
// instr_fetch: single-issue instruction fetch from a one-cycle synchronous ROM
// with stall hold, jump redirect and out-of-range error trapping.
module instr_fetch #(
   parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
   parameter int          MEM_SIZE_WORDS = 2**12
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_rdata_i,
   input  logic        stall_i,
   input  logic        jmp_i,
   input  logic [31:0] jmp_addr_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_addr_o,
   output logic        instr_valid_o,
   output logic        instr_err_o
);
   localparam logic [32:0] LIMIT = 33'(MEM_SIZE_WORDS) << 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;
   state_t      state_q, state_d;
   logic [31:0] iaddr_q;
   logic        unused_jmp_lsb;
   assign unused_jmp_lsb = ^jmp_addr_i[1:0];
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         state_q <= BOOT;
         iaddr_q <= BOOT_ADDR;
      end else begin
         state_q <= state_d;
         iaddr_q <= rom_addr_o;
      end
   // Range is judged on the 33-bit address so a full 4 GiB ROM never traps.
   always_comb
      state_d = (state_q == ERR && !jmp_i) ? ERR : ({1'b0, rom_addr_o} >= LIMIT) ? ERR : RUN;
   always_comb begin
      rom_addr_o    = state_q == BOOT ? BOOT_ADDR :
                      jmp_i ? {jmp_addr_i[31:2], 2'b00} :
                      (state_q == ERR || stall_i) ? iaddr_q : iaddr_q + 32'd4;
      instr_valid_o = state_q == RUN && !jmp_i;
      instr_o       = instr_valid_o ? rom_rdata_i : NOP;
      instr_err_o   = state_q == ERR;
   end
   assign instr_addr_o = iaddr_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench driving a 4-word ROM fetch unit and a full
// 4 GiB one with identical stimulus, compared against a PC-level reference model.
module tb_instr_fetch;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [32:0] LIM_A = 33'd16;
   localparam logic [32:0] LIM_B = 33'h1_0000_0000;
   typedef struct { logic boot; logic [31:0] pc; } mdl_t;
   typedef struct { logic [31:0] rom_addr, instr, iaddr; logic valid, err; } exp_t;
   logic clk = 1'b0, rstn = 1'b0, stall = 1'b0, jmp = 1'b0;
   logic [31:0] jaddr = 32'h0;
   logic [31:0] rom_addr_a, rdata_a, instr_a, iaddr_a, rom_addr_b, rdata_b, instr_b, iaddr_b;
   logic        valid_a, err_a, valid_b, err_b;
   int          checks = 0, failures = 0;
   mdl_t        ma, mb;
   exp_t        qa[$], qb[$];

   always #5 clk = ~clk;

   instr_fetch #(.BOOT_ADDR(32'h0), .MEM_SIZE_WORDS(4)) dut_a (
      .clk_i(clk), .rstn_i(rstn), .rom_addr_o(rom_addr_a), .rom_rdata_i(rdata_a),
      .stall_i(stall), .jmp_i(jmp), .jmp_addr_i(jaddr), .instr_o(instr_a),
      .instr_addr_o(iaddr_a), .instr_valid_o(valid_a), .instr_err_o(err_a));
   instr_fetch #(.BOOT_ADDR(32'h0), .MEM_SIZE_WORDS(2**30)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .rom_addr_o(rom_addr_b), .rom_rdata_i(rdata_b),
      .stall_i(stall), .jmp_i(jmp), .jmp_addr_i(jaddr), .instr_o(instr_b),
      .instr_addr_o(iaddr_b), .instr_valid_o(valid_b), .instr_err_o(err_b));

   function automatic logic [31:0] rom_word(logic [31:0] a);
      return 32'hAAAA_0001 + {2'b00, a[31:2]};
   endfunction

   always @(posedge clk) begin
      rdata_a <= rom_word(rom_addr_a);
      rdata_b <= rom_word(rom_addr_b);
   end

   // Reference: after boot, the fetcher is in error exactly when its held PC is outside the ROM.
   function automatic logic bad(mdl_t m, logic [32:0] lim);
      return !m.boot && ({1'b0, m.pc} >= lim);
   endfunction

   function automatic logic [31:0] issue(mdl_t m, logic [32:0] lim, logic st, logic j, logic [31:0] ja);
      if (m.boot) return 32'h0;
      if (j) return ja & 32'hFFFF_FFFC;
      if (bad(m, lim) || st) return m.pc;
      return m.pc + 32'd4;
   endfunction

   function automatic mdl_t advance(mdl_t m, logic [32:0] lim);
      mdl_t r;
      r.boot = !rstn;
      r.pc   = rstn ? issue(m, lim, stall, jmp, jaddr) : 32'h0;
      return r;
   endfunction

   function automatic exp_t exp_of(mdl_t m, logic [32:0] lim);
      exp_t e;
      e.rom_addr = issue(m, lim, stall, jmp, jaddr);
      e.err      = bad(m, lim);
      e.valid    = !m.boot && !e.err && !jmp;
      e.instr    = e.valid ? rom_word(m.pc) : NOP;
      e.iaddr    = m.pc;
      return e;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, act, req);
      end
   endtask

   task automatic cmp_all(input string t, input exp_t e, input logic [31:0] ra, ins, ia,
                          input logic v, er);
      chk({t, "_rom_addr"}, ra, e.rom_addr);
      chk({t, "_instr"}, ins, e.instr);
      chk({t, "_instr_addr"}, ia, e.iaddr);
      chk({t, "_valid"}, {31'b0, v}, {31'b0, e.valid});
      chk({t, "_err"}, {31'b0, er}, {31'b0, e.err});
   endtask

   always @(negedge clk) begin
      if (qa.size() > 0) cmp_all("a", qa.pop_front(), rom_addr_a, instr_a, iaddr_a, valid_a, err_a);
      if (qb.size() > 0) cmp_all("b", qb.pop_front(), rom_addr_b, instr_b, iaddr_b, valid_b, err_b);
   end

   task automatic push_exp();
      qa.push_back(exp_of(ma, LIM_A));
      qb.push_back(exp_of(mb, LIM_B));
   endtask

   task automatic cycle(input logic r, st, j, input logic [31:0] ja);
      @(posedge clk);
      #1;
      ma = advance(ma, LIM_A);
      mb = advance(mb, LIM_B);
      rstn = r; stall = st; jmp = j; jaddr = ja;
      if (!rstn) begin
         ma = '{1'b1, 32'h0};
         mb = '{1'b1, 32'h0};
      end
      push_exp();
   endtask

   task automatic reset_mid_stall();
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      ma = advance(ma, LIM_A);
      mb = advance(mb, LIM_B);
      #2 rstn = 1'b0;
      #1;
      chk("rst_rom_addr", rom_addr_a | rom_addr_b, 32'h0);
      chk("rst_instr_a", instr_a, NOP);
      chk("rst_instr_b", instr_b, NOP);
      chk("rst_instr_addr", iaddr_a | iaddr_b, 32'h0);
      chk("rst_valid", {30'b0, valid_a, valid_b}, 32'h0);
      chk("rst_err", {30'b0, err_a, err_b}, 32'h0);
      ma = '{1'b1, 32'h0};
      mb = '{1'b1, 32'h0};
      push_exp();
   endtask

   initial begin
      ma = '{1'b1, 32'h0};
      mb = '{1'b1, 32'h0};
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 32'h4);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 32'h103);
      cycle(1'b1, 1'b1, 1'b1, 32'h13);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF1);
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      reset_mid_stall();
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ja;
         case ($urandom_range(0, 2))
            0:       ja = $urandom_range(0, 19);
            1:       ja = 32'hFFFF_FFE0 + $urandom_range(0, 31);
            default: ja = $urandom;
         endcase
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, ja);
      end
      @(posedge clk);
      #1;
      chk("drain", qa.size() + qb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
